fft_twiddle_sequencer: RTL and testbench

- Control-side initiator that drives the twiddle_LUT index port and the butterfly data-memory addresses for an in-place radix-2 DIT FFT/IFFT.
- Per frame, walks every stage and every butterfly, emitting one (addr_a, addr_b, tw_index) triple per handshake.
- Sits between the frame controller (start/done) and the butterfly datapath plus twiddle_LUT (valid/ready).

---
 rtl/fft_pkg.sv | 32 +++
 rtl/fft_bfly_addr.sv | 56 +++++
 rtl/fft_twiddle_sequencer.sv | 176 +++++++++++++++++
 tb/tb_fft_twiddle_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_pkg
// Description : Shared sizing helpers, sequencer state type and address type
//               for the radix-2 DIT FFT twiddle/address sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

    localparam int FFT_POINTS_DEFAULT = 16;

    function automatic int fft_log2n(input int n);
        return $clog2(n);
    endfunction

    function automatic int fft_stage_w(input int n);
        return $clog2($clog2(n));
    endfunction

    localparam int FFT_LOG2N = fft_log2n(FFT_POINTS_DEFAULT);
    localparam int FFT_SW    = fft_stage_w(FFT_POINTS_DEFAULT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    typedef logic [FFT_LOG2N-1:0] fft_addr_t;

endpackage
`default_nettype wire

// File: rtl/fft_bfly_addr.sv
`default_nettype none
// ============================================================================
// Module      : fft_bfly_addr
// Description : Combinational butterfly address / twiddle-index generator for
//               stage s and butterfly b of an in-place radix-2 DIT FFT.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_bfly_addr
    import fft_pkg::*;
#(
    parameter  int FFT_POINTS = FFT_POINTS_DEFAULT,
    localparam int LOG2N      = fft_log2n(FFT_POINTS),
    localparam int SW         = fft_stage_w(FFT_POINTS)
) (
    input  logic [SW-1:0]    s_i,
    input  logic [LOG2N-2:0] b_i,
    input  logic             inverse_i,
    output logic [LOG2N-1:0] addr_a_o,
    output logic [LOG2N-1:0] addr_b_o,
    output logic [LOG2N-1:0] tw_index_o,
    output logic             stage_last_o,
    output logic             frame_last_o
);

    localparam logic [LOG2N-1:0] C_ONE_A  = LOG2N'(1);
    localparam logic [LOG2N-1:0] C_ZERO_A = '0;
    localparam logic [SW-1:0]    C_LAST_S = SW'(LOG2N - 1);

    logic [LOG2N-1:0] w_span;
    logic [LOG2N-1:0] w_b_ext;
    logic [LOG2N-1:0] w_j;
    logic [LOG2N-1:0] w_g;
    logic [LOG2N-1:0] w_addr_a;
    logic [LOG2N-1:0] w_k;
    logic [SW-1:0]    w_kshift;

    always_comb begin
        w_span   = C_ONE_A << s_i;
        w_b_ext  = {1'b0, b_i};
        w_j      = w_b_ext & (w_span - C_ONE_A);
        w_g      = w_b_ext >> s_i;
        // Two shifts avoid overflowing s+1 in the SW-bit stage width.
        w_addr_a = ((w_g << s_i) << 1) | w_j;
        w_kshift = C_LAST_S - s_i;
        w_k      = w_j << w_kshift;
    end

    assign addr_a_o     = w_addr_a;
    assign addr_b_o     = w_addr_a + w_span;
    // Conjugate twiddle: (N-k) mod N falls out of LOG2N-bit wraparound.
    assign tw_index_o   = inverse_i ? (C_ZERO_A - w_k) : w_k;
    assign stage_last_o = &b_i;
    assign frame_last_o = (&b_i) & (s_i == C_LAST_S);

endmodule
`default_nettype wire

// File: rtl/fft_twiddle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fft_twiddle_sequencer
// Description : Walks every stage/butterfly of an in-place radix-2 DIT FFT and
//               emits registered (addr_a, addr_b, tw_index) triples over a
//               valid/ready handshake, framed by start/busy/done.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_twiddle_sequencer
    import fft_pkg::*;
#(
    parameter  int FFT_POINTS = FFT_POINTS_DEFAULT,
    localparam int LOG2N      = fft_log2n(FFT_POINTS),
    localparam int SW         = fft_stage_w(FFT_POINTS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             inverse,
    output logic             busy,
    output logic             done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SW-1:0]    stage,
    output logic [LOG2N-1:0] addr_a,
    output logic [LOG2N-1:0] addr_b,
    output logic [LOG2N-1:0] tw_index,
    output logic             stage_last,
    output logic             frame_last
);

    localparam logic [LOG2N-2:0] C_B_ONE = (LOG2N-1)'(1);
    localparam logic [SW-1:0]    C_S_ONE = SW'(1);

    seq_state_t       state_q;
    logic             busy_q;
    logic             done_q;
    logic             valid_q;
    logic             inv_q;
    logic [SW-1:0]    s_q;
    logic [LOG2N-2:0] b_q;
    logic [LOG2N-1:0] addr_a_q;
    logic [LOG2N-1:0] addr_b_q;
    logic [LOG2N-1:0] tw_q;
    logic             sl_q;
    logic             fl_q;

    logic [SW-1:0]    s_d;
    logic [LOG2N-2:0] b_d;
    logic             inv_d;

    logic             w_hs;
    logic [LOG2N-1:0] w_addr_a;
    logic [LOG2N-1:0] w_addr_b;
    logic [LOG2N-1:0] w_tw;
    logic             w_sl;
    logic             w_fl;

    assign w_hs = valid_q & out_ready;

    // Next butterfly position; the address generator runs one step ahead so
    // the triple is already registered when its butterfly becomes current.
    always_comb begin
        s_d   = s_q;
        b_d   = b_q;
        inv_d = inv_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    s_d   = '0;
                    b_d   = '0;
                    inv_d = inverse;
                end
            end
            RUN: begin
                if (w_hs && !fl_q) begin
                    if (sl_q) begin
                        b_d = '0;
                        s_d = s_q + C_S_ONE;
                    end else begin
                        b_d = b_q + C_B_ONE;
                    end
                end
            end
            default: ;
        endcase
    end

    fft_bfly_addr #(
        .FFT_POINTS (FFT_POINTS)
    ) u_bfly_addr (
        .s_i          (s_d),
        .b_i          (b_d),
        .inverse_i    (inv_d),
        .addr_a_o     (w_addr_a),
        .addr_b_o     (w_addr_b),
        .tw_index_o   (w_tw),
        .stage_last_o (w_sl),
        .frame_last_o (w_fl)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            inv_q    <= 1'b0;
            s_q      <= '0;
            b_q      <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            tw_q     <= '0;
            sl_q     <= 1'b0;
            fl_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= RUN;
                        busy_q   <= 1'b1;
                        valid_q  <= 1'b1;
                        inv_q    <= inv_d;
                        s_q      <= s_d;
                        b_q      <= b_d;
                        addr_a_q <= w_addr_a;
                        addr_b_q <= w_addr_b;
                        tw_q     <= w_tw;
                        sl_q     <= w_sl;
                        fl_q     <= w_fl;
                    end
                end
                RUN: begin
                    if (w_hs) begin
                        if (fl_q) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            s_q      <= s_d;
                            b_q      <= b_d;
                            addr_a_q <= w_addr_a;
                            addr_b_q <= w_addr_b;
                            tw_q     <= w_tw;
                            sl_q     <= w_sl;
                            fl_q     <= w_fl;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign out_valid  = valid_q;
    assign stage      = s_q;
    assign addr_a     = addr_a_q;
    assign addr_b     = addr_b_q;
    assign tw_index   = tw_q;
    assign stage_last = sl_q;
    assign frame_last = fl_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_twiddle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_twiddle_sequencer
// Description : Self-checking bench for fft_twiddle_sequencer (N=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_twiddle_sequencer;

    localparam int N     = 16;
    localparam int LG    = 4;
    localparam int TOTAL = (N / 2) * LG;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       start     = 1'b0;
    logic       inverse   = 1'b0;
    logic       out_ready = 1'b0;
    logic       busy;
    logic       done;
    logic       out_valid;
    logic [1:0] stage;
    logic [3:0] addr_a;
    logic [3:0] addr_b;
    logic [3:0] tw_index;
    logic       stage_last;
    logic       frame_last;

    fft_twiddle_sequencer #(
        .FFT_POINTS (N)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .inverse    (inverse),
        .busy       (busy),
        .done       (done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .stage      (stage),
        .addr_a     (addr_a),
        .addr_b     (addr_b),
        .tw_index   (tw_index),
        .stage_last (stage_last),
        .frame_last (frame_last)
    );

    always #5 clk = ~clk;

    int nvec      = 0;
    int nerr      = 0;
    int cyc       = 0;
    int last_done = -1;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int a;
        int b;
        int tw;
        int s;
        int sl;
        int fl;
    } trip_t;

    trip_t gold [TOTAL];

    // Textbook DIT loop nest: stage, group, offset within group.
    task automatic build_gold(input bit inv);
        int n = 0;
        for (int s = 0; s < LG; s++) begin
            int span   = 2 ** s;
            int groups = N / (2 * span);
            for (int g = 0; g < groups; g++) begin
                for (int j = 0; j < span; j++) begin
                    int k = j * (N / (2 * span));
                    gold[n].a  = g * 2 * span + j;
                    gold[n].b  = g * 2 * span + j + span;
                    gold[n].tw = inv ? ((N - k) % N) : k;
                    gold[n].s  = s;
                    gold[n].sl = (g == groups - 1 && j == span - 1) ? 1 : 0;
                    gold[n].fl = (gold[n].sl == 1 && s == LG - 1) ? 1 : 0;
                    n++;
                end
            end
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_triple(input int idx);
        chk("addr_a", 32'(addr_a), gold[idx].a);
        chk("addr_b", 32'(addr_b), gold[idx].b);
        chk("tw_index", 32'(tw_index), gold[idx].tw);
        chk("stage", 32'(stage), gold[idx].s);
        chk("stage_last", 32'(stage_last), gold[idx].sl);
        chk("frame_last", 32'(frame_last), gold[idx].fl);
    endtask

    task automatic do_frame(input bit inv, input int ready_pct, input bit hold, input bit poke);
        int idx   = 0;
        int guard = 0;
        int n_sl  = 0;
        bit sl_seen;
        build_gold(inv);
        start   = 1'b1;
        inverse = inv;
        tick;
        if (!hold) start = 1'b0;
        chk("busy_after_start", 32'(busy), 1);
        chk("valid_after_start", 32'(out_valid), 1);
        while (idx < TOTAL && guard < 1000) begin
            chk("valid_run", 32'(out_valid), 1);
            chk("busy_run", 32'(busy), 1);
            chk("done_run", 32'(done), 0);
            check_triple(idx);
            if (!inv && idx == 9) begin
                chk("s1b1_addr_a", 32'(addr_a), 1);
                chk("s1b1_addr_b", 32'(addr_b), 3);
                chk("s1b1_tw", 32'(tw_index), 4);
            end
            if (inv && idx == 9)  chk("inv_s1j1_tw", 32'(tw_index), 12);
            if (inv && idx == 25) chk("inv_s3j1_tw", 32'(tw_index), 15);
            if (!inv && idx >= 24) chk("s3_tw", 32'(tw_index), idx - 24);
            sl_seen   = stage_last;
            out_ready = ($urandom_range(99) < 32'(ready_pct));
            if (poke) begin
                start   = 1'($urandom_range(1));
                inverse = 1'($urandom_range(1));
            end
            tick;
            guard++;
            if (out_ready) begin
                if (sl_seen) n_sl++;
                idx++;
            end
        end
        chk("handshakes", idx, TOTAL);
        chk("stage_last_count", n_sl, 4);
        chk("done_pulse", 32'(done), 1);
        chk("busy_at_done", 32'(busy), 0);
        chk("valid_at_done", 32'(out_valid), 0);
        if (hold && last_done >= 0) chk("done_gap", cyc - last_done, TOTAL + 2);
        last_done = cyc;
        if (poke) start = 1'b1;
        tick;
        chk("done_single", 32'(done), 0);
        chk("valid_idle", 32'(out_valid), 0);
        chk("busy_idle", 32'(busy), 0);
        if (!hold) begin
            start = 1'b0;
            tick;
            chk("no_dup_valid", 32'(out_valid), 0);
            chk("no_dup_busy", 32'(busy), 0);
            chk("no_dup_done", 32'(done), 0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        tick;
        tick;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_stage", 32'(stage), 0);
        chk("rst_addr_a", 32'(addr_a), 0);
        chk("rst_addr_b", 32'(addr_b), 0);
        chk("rst_tw", 32'(tw_index), 0);
        chk("rst_sl", 32'(stage_last), 0);
        chk("rst_fl", 32'(frame_last), 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick;
        chk("idle_no_start", 32'(out_valid), 0);

        do_frame(1'b0, 100, 1'b0, 1'b0);
        do_frame(1'b1, 100, 1'b0, 1'b0);
        do_frame(1'b0, 50, 1'b0, 1'b0);
        do_frame(1'b1, 50, 1'b0, 1'b0);
        do_frame(1'b0, 70, 1'b0, 1'b1);
        do_frame(1'b1, 70, 1'b0, 1'b1);

        // Reset lands on the edge of the 10th handshake.
        build_gold(1'b0);
        out_ready = 1'b1;
        start     = 1'b1;
        inverse   = 1'b0;
        tick;
        start = 1'b0;
        repeat (9) tick;
        check_triple(9);
        rst_n = 1'b0;
        tick;
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_addr_a", 32'(addr_a), 0);
        rst_n = 1'b1;
        repeat (5) begin
            tick;
            chk("postrst_done", 32'(done), 0);
            chk("postrst_valid", 32'(out_valid), 0);
        end
        do_frame(1'b0, 100, 1'b0, 1'b0);

        last_done = -1;
        repeat (3) do_frame(1'b0, 100, 1'b1, 1'b0);
        start = 1'b0;
        tick;
        chk("final_idle_valid", 32'(out_valid), 0);
        tick;
        chk("final_idle_busy", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
